// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main sequencing FSM of the multi-cycle core. It walks each instruction
//   through fetch, decode, execute, memory and writeback. It performs
//   valid/ready handshakes with the instruction and data memory ports, and it
//   halts on ebreak, a bus error or a handshake timeout. It also keeps the cycle
//   and retired-instruction counters that the simulation harness reads.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   imem_req_valid    fetch request (Moore, FETCH)
//   imem_req_ready    fetch request accepted
//   imem_rsp_valid    instruction word valid (sampled only in IWAIT)
//   imem_rsp_err      fetch bus error, qualified by imem_rsp_valid
//   dec_is_mem        load/store flag, sampled in EXEC
//   dec_wen           rd write flag, sampled in WB
//   dec_ebreak        ebreak flag, sampled in WB
//   lsu_req_valid     data request (Moore, MEM)
//   lsu_req_ready     data request accepted
//   lsu_rsp_valid     load data / store ack valid (sampled only in MWAIT)
//   lsu_rsp_err       data bus error, qualified by lsu_rsp_valid
//   ir_wen            instruction register load strobe
//   rf_wen            register-file write strobe
//   pc_wen            PC update strobe
//   state             current state code, for debug
//   halted            core stopped
//   halt_cause        0 none, 1 ebreak, 2 bus error, 3 timeout
//   cycle_cnt         active cycles (not IDLE, not HALT)
//   instret_cnt       retired instructions
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic             imem_rsp_err,
  input  logic             dec_is_mem,
  input  logic             dec_wen,
  input  logic             dec_ebreak,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic             lsu_rsp_err,
  output logic             ir_wen,
  output logic             rf_wen,
  output logic             pc_wen,
  output logic [3:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    IWAIT  = 4'd2,
    DECODE = 4'd3,
    EXEC   = 4'd4,
    MEM    = 4'd5,
    MWAIT  = 4'd6,
    WB     = 4'd7,
    HALT   = 4'd8
  } state_t;

  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_BUS_ERR = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // The wait counter never has to hold more than TIMEOUT-1, because a handshake
  // state is always left at that count.
  localparam int              WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t             state_reg, state_next;
  logic [1:0]         cause_reg, cause_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic [CNT_W-1:0]   cycle_reg, instret_reg;
  logic               timed_out;
  logic               in_wait_state;

  assign timed_out     = (wait_reg == WAIT_LAST);
  assign in_wait_state = (state_reg == FETCH) || (state_reg == IWAIT) ||
                         (state_reg == MEM)   || (state_reg == MWAIT);

  // Next state and strobes. Within a handshake state the priority is
  // error > completion > timeout, so a completion on the last allowed cycle
  // still proceeds normally.
  always_comb begin
    state_next     = state_reg;
    cause_next     = cause_reg;
    imem_req_valid = 1'b0;
    lsu_req_valid  = 1'b0;
    ir_wen         = 1'b0;
    rf_wen         = 1'b0;
    pc_wen         = 1'b0;
    case (state_reg)
      IDLE:   state_next = FETCH;
      FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_next = IWAIT;
        end else if (timed_out) begin
          state_next = HALT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      IWAIT: begin
        if (imem_rsp_valid && imem_rsp_err) begin
          state_next = HALT;
          cause_next = CAUSE_BUS_ERR;
        end else if (imem_rsp_valid) begin
          ir_wen     = 1'b1;
          state_next = DECODE;
        end else if (timed_out) begin
          state_next = HALT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      DECODE: state_next = EXEC;
      EXEC:   state_next = dec_is_mem ? MEM : WB;
      MEM: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) begin
          state_next = MWAIT;
        end else if (timed_out) begin
          state_next = HALT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      MWAIT: begin
        if (lsu_rsp_valid && lsu_rsp_err) begin
          state_next = HALT;
          cause_next = CAUSE_BUS_ERR;
        end else if (lsu_rsp_valid) begin
          state_next = WB;
        end else if (timed_out) begin
          state_next = HALT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      WB: begin
        rf_wen = dec_wen;
        if (dec_ebreak) begin
          state_next = HALT;
          cause_next = CAUSE_EBREAK;
        end else begin
          pc_wen     = 1'b1;
          state_next = FETCH;
        end
      end
      HALT:   state_next = HALT;
      default: begin
        // Corrupted state code: stop the core and report it as a timeout.
        state_next = HALT;
        cause_next = CAUSE_TIMEOUT;
      end
    endcase
  end

  // The wait counter restarts whenever a handshake state is entered, and it
  // counts the cycles already spent in that state.
  always_comb begin
    wait_next = '0;
    if (in_wait_state && (state_next == state_reg)) begin
      wait_next = wait_reg + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cause_reg   <= 2'd0;
      wait_reg    <= '0;
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      wait_reg  <= wait_next;
      if ((state_reg != IDLE) && (state_reg != HALT)) begin
        cycle_reg <= cycle_reg + CNT_W'(1);
      end
      if (state_reg == WB) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  assign state       = state_reg;
  assign halted      = (state_reg == HALT);
  assign halt_cause  = cause_reg;
  assign cycle_cnt   = cycle_reg;
  assign instret_cnt = instret_reg;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main sequencing FSM for the multi-cycle core. It drives the IFU, IDU, EXU, LSU and register-file write enables through fetch, decode, execute, memory and writeback, one instruction at a time.
- It performs valid/ready handshakes with the instruction and data memory ports.
- It halts the core on ebreak, bus error or response timeout, and keeps cycle and retired-instruction counters for the simulation harness.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt (wrap modulo 2^CNT_W).
- TIMEOUT, 256, maximum cycles spent in one handshake state before timeout halt (≥2).

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  instruction fetch request (PC supplied by the PC register).
- imem_req_ready  in  1  IFU accepts request.
- imem_rsp_valid  in  1  instruction word valid.
- imem_rsp_err  in  1  fetch bus error, qualified by imem_rsp_valid.
- dec_is_mem  in  1  decoded instruction is load/store; sampled in EXEC.
- dec_wen  in  1  decoded instruction writes rd; sampled in WB.
- dec_ebreak  in  1  decoded instruction is ebreak; sampled in WB.
- lsu_req_valid  out  1  data memory request.
- lsu_req_ready  in  1  LSU accepts request.
- lsu_rsp_valid  in  1  load data / store ack valid.
- lsu_rsp_err  in  1  data bus error, qualified by lsu_rsp_valid.
- ir_wen  out  1  instruction register load strobe.
- rf_wen  out  1  register-file write strobe.
- pc_wen  out  1  PC update strobe.
- state  out  4  current state, for debug.
- halted  out  1  core stopped.
- halt_cause  out  2  halt reason: 0 none, 1 ebreak, 2 bus error, 3 timeout.
- cycle_cnt  out  CNT_W  active cycle count.
- instret_cnt  out  CNT_W  retired instruction count.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All strobes and valids 0; halted=0; halt_cause=0; counters 0; wait counter 0.
- State encoding: IDLE=0, FETCH=1, IWAIT=2, DECODE=3, EXEC=4, MEM=5, MWAIT=6, WB=7, HALT=8. Unused codes go to HALT with cause 3.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH: imem_req_valid=1 (Moore). On imem_req_ready -> IWAIT.
  - IWAIT: response is sampled only in this state.
    - imem_rsp_valid & ~imem_rsp_err: ir_wen=1 (Mealy, that cycle), go to DECODE.
    - imem_rsp_valid & imem_rsp_err: go to HALT, cause 2; ir_wen=0.
  - DECODE -> EXEC. One cycle, no outputs.
  - EXEC: dec_is_mem -> MEM, else -> WB.
  - MEM: lsu_req_valid=1 (Moore). On lsu_req_ready -> MWAIT.
  - MWAIT:
    - lsu_rsp_valid & ~lsu_rsp_err -> WB.
    - lsu_rsp_valid & lsu_rsp_err -> HALT, cause 2.
  - WB:
    - rf_wen=dec_wen for one cycle; instret_cnt+1.
    - dec_ebreak: pc_wen=0, go to HALT, cause 1 (ebreak counts as retired).
    - otherwise: pc_wen=1, go to FETCH.
  - HALT: absorbing state. halted=1; all strobes and valids 0; exited only by reset.
- Handshakes:
  - A valid, once raised, is held until ready; there is no retraction.
  - A response arriving in the same cycle the request is accepted is ignored.
- Timeout:
  - The wait counter clears on entry to FETCH, IWAIT, MEM and MWAIT, and increments each cycle spent in those states.
  - If the wait counter reaches TIMEOUT-1 and the state's completing condition is still not met, the next state is HALT, cause 3.
  - Completion on that same cycle takes priority over the timeout.
- Priority inside one state: error > completion > timeout.
- cycle_cnt increments every cycle the state is not IDLE and not HALT. It wraps to 0 after all-ones; instret_cnt wraps the same way.
- Latency with zero-wait memory (req_ready=1, response one cycle after accept):
  - Non-memory instruction: 5 cycles (FETCH, IWAIT, DECODE, EXEC, WB).
  - Load/store: 7 cycles.
- halt_cause is written once on entry to HALT and holds until reset.
- Reset asserted mid-instruction aborts immediately: no strobe is emitted, and the core restarts from IDLE.

Test Plan:
- Zero-wait ALU stream:
  - Stimulus: 3 instructions, dec_wen=1, dec_is_mem=0.
  - Required: pc_wen pulses at cycles 6, 11, 16 after reset release; instret_cnt=3; rf_wen asserted 3 times.
- Stalled fetch and load:
  - Stimulus: imem_req_ready low for 4 cycles; then a load with a 3-cycle lsu response delay.
  - Required: imem_req_valid held 5 cycles; WB reached 13 cycles after FETCH entry; exactly one rf_wen.
- ebreak:
  - Stimulus: dec_ebreak=1 in WB.
  - Required: halted=1 and halt_cause=1 next cycle; no pc_wen; instret_cnt+1; cycle_cnt frozen thereafter.
- Bus error:
  - Stimulus: imem_rsp_err=1 with imem_rsp_valid in IWAIT.
  - Required: ir_wen stays 0; HALT with cause 2.
  - Repeat with lsu_rsp_err in MWAIT -> cause 2, rf_wen never pulses.
- Timeout (TIMEOUT=8):
  - Stimulus: lsu_req_ready stuck at 0.
  - Required: HALT with cause 3 after 8 cycles in MEM.
  - Stimulus: ready asserted on the 8th cycle.
  - Required: proceeds to MWAIT, no halt.
- Async reset mid-MWAIT:
  - Stimulus: rst=0 between clock edges.
  - Required: state=0, counters 0 and all outputs 0 immediately; after release, FETCH on the 2nd edge.
